// File: rtl/codecache_pkg.sv
// Shared constants, state encodings and address helpers for the code-cache refill engine.
package codecache_pkg;

  localparam int LINE_BYTES = 16;
  localparam int OFFS_W     = $clog2(LINE_BYTES);
  localparam int IDX_W      = 8;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 32 - OFFS_W;

  // Fill sequencer states, kept as plain constants so older tools can share them.
  typedef logic [2:0] fill_state_t;
  localparam fill_state_t ST_INIT   = 3'd0;
  localparam fill_state_t ST_IDLE   = 3'd1;
  localparam fill_state_t ST_FETCH  = 3'd2;
  localparam fill_state_t ST_INSERT = 3'd3;
  localparam fill_state_t ST_DONE   = 3'd4;

  function automatic logic [LINE_W-1:0] line_addr(input logic [31:0] addr);
    return addr[31:OFFS_W];
  endfunction

endpackage

// File: rtl/codecache_line_buf.sv
// Line assembly buffer: one 32-bit register per word slot, written by slot as beats arrive.
module codecache_line_buf
  import codecache_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [1:0]              wr_slot,
  input  logic [WORD_W-1:0]       wr_data,
  output logic [WORDS*WORD_W-1:0] line
);

  logic [WORD_W-1:0] words [WORDS];

  // Word registers; a beat lands in the slot named by its address, not its arrival order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        words[i] <= {WORD_W{1'b0}};
      end
    end else if (wr_en) begin
      words[wr_slot] <= wr_data;
    end
  end

  // Flatten with slot 0 in the low word.
  always_comb begin
    line = {(WORDS*WORD_W){1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      line[i*WORD_W +: WORD_W] = words[i];
    end
  end

endmodule

// File: rtl/codecache_fill.sv
// Refill engine for the 4-way code cache: init sweep after reset, then 4-beat line fills.
// Critical-word-first beat order is enabled by defining CODECACHE_FILL_CRITICAL_WORD_EN.
module codecache_fill
  import codecache_pkg::*;
#(
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req,
  input  logic [31:0]                  miss_addr,
  output logic                         miss_ready,
  output logic                         fill_done,
  output logic                         busy,
  output logic [31:0]                  cc_addr,
  output logic                         cc_insert,
  output logic                         cc_initEntry,
  output logic [LINE_WORDS*WORD_W-1:0] cc_cacheLine,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_rdata
`ifdef CODECACHE_FILL_CRITICAL_WORD_EN
  ,
  output logic                         crit_valid,
  output logic [31:0]                  crit_data
`endif
);

  localparam logic [IDX_W:0] INIT_END = (IDX_W+1)'(SETS);

  fill_state_t       state, state_n;
  logic [IDX_W:0]    init_cnt, init_cnt_n;
  logic [LINE_W-1:0] line, line_n;
  logic [1:0]        beat, beat_n;
  logic [1:0]        start, start_n;
  logic [1:0]        miss_slot;
  logic              accept;
  logic              ack;
  logic              unused_bits;

`ifdef CODECACHE_FILL_CRITICAL_WORD_EN
  assign miss_slot   = miss_addr[3:2];
  assign unused_bits = ^miss_addr[1:0];
`else
  assign miss_slot   = 2'd0;
  assign unused_bits = ^miss_addr[3:0];
`endif

  // Next-state and fill bookkeeping.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    line_n     = line;
    beat_n     = beat;
    start_n    = start;
    accept     = 1'b0;
    ack        = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_END) begin
          state_n = ST_IDLE;
        end else begin
          init_cnt_n = init_cnt + {{IDX_W{1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (miss_req && miss_ready) begin
          accept  = 1'b1;
          state_n = ST_FETCH;
          line_n  = line_addr(miss_addr);
          beat_n  = 2'd0;
          start_n = miss_slot;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          ack     = 1'b1;
          beat_n  = beat + 2'd1;
          state_n = (beat == 2'd3) ? ST_INSERT : ST_FETCH;
        end else begin
          state_n = ST_FETCH;
        end
      end
      ST_INSERT: state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_INIT;
    endcase
  end

  // State registers; every output is registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      init_cnt     <= {(IDX_W+1){1'b0}};
      line         <= {LINE_W{1'b0}};
      beat         <= 2'd0;
      start        <= 2'd0;
      miss_ready   <= 1'b0;
      busy         <= 1'b1;
      fill_done    <= 1'b0;
      cc_insert    <= 1'b0;
      cc_initEntry <= 1'b0;
      mem_req      <= 1'b0;
      cc_addr      <= 32'd0;
      mem_addr     <= 32'd0;
    end else begin
      state        <= state_n;
      init_cnt     <= init_cnt_n;
      line         <= line_n;
      beat         <= beat_n;
      start        <= start_n;
      miss_ready   <= (state_n == ST_IDLE);
      busy         <= (state_n != ST_IDLE);
      fill_done    <= (state_n == ST_DONE);
      cc_insert    <= (state_n == ST_INSERT);
      cc_initEntry <= (state_n == ST_INIT);
      mem_req      <= (state_n == ST_FETCH);
      if (state_n == ST_INIT) begin
        cc_addr <= {{(32-IDX_W-OFFS_W){1'b0}}, init_cnt[IDX_W-1:0], {OFFS_W{1'b0}}};
      end else if (accept) begin
        cc_addr <= {line_n, {OFFS_W{1'b0}}};
      end
      // Beat address follows the rotated order; it only moves on an ack.
      if (state_n == ST_FETCH) begin
        mem_addr <= {line_n, start_n + beat_n, 2'b00};
      end
    end
  end

  codecache_line_buf #(
    .WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ack),
    .wr_slot (mem_addr[3:2]),
    .wr_data (mem_rdata),
    .line    (cc_cacheLine)
  );

`ifdef CODECACHE_FILL_CRITICAL_WORD_EN
  // The missed word is always the first beat of a fill.
  assign crit_valid = ack && (beat == 2'd0);
  assign crit_data  = mem_rdata;
`endif

endmodule

// File: tb/tb_codecache_fill.sv
// Directed bench for codecache_fill: init sweep, zero-wait and slow fills, overlapping miss, reset abort.
module tb_codecache_fill;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         fill_done;
  logic         busy;
  logic [31:0]  cc_addr;
  logic         cc_insert;
  logic         cc_initEntry;
  logic [127:0] cc_cacheLine;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
`ifdef CODECACHE_FILL_CRITICAL_WORD_EN
  logic         crit_valid;
  logic [31:0]  crit_data;
  int           crit_cnt = 0;
  logic [31:0]  crit_word = 32'd0;
`endif

  localparam logic [127:0] LINE_EXP = {32'h44, 32'h33, 32'h22, 32'h11};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 0;
  int ack_n = 0;
  int unstable = 0;
  logic [31:0] ack_addr [64];
  int ins_cnt = 0;
  int ins_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [127:0] ins_line = 128'd0;
  logic [31:0]  ins_addr = 32'd0;

  codecache_fill dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .fill_done    (fill_done),
    .busy         (busy),
    .cc_addr      (cc_addr),
    .cc_insert    (cc_insert),
    .cc_initEntry (cc_initEntry),
    .cc_cacheLine (cc_cacheLine),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
`ifdef CODECACHE_FILL_CRITICAL_WORD_EN
    ,
    .crit_valid   (crit_valid),
    .crit_data    (crit_data)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Insert / done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (cc_insert) begin
      ins_cnt  <= ins_cnt + 1;
      ins_cyc  <= cyc;
      ins_line <= cc_cacheLine;
      ins_addr <= cc_addr;
    end
    if (fill_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

`ifdef CODECACHE_FILL_CRITICAL_WORD_EN
  always @(posedge clk) begin
    if (crit_valid) begin
      crit_cnt  <= crit_cnt + 1;
      crit_word <= crit_data;
    end
  end
`endif

  // Memory responder: acks after mem_lat waiting cycles; word in slot s is 0x11*(s+1).
  initial begin
    int wcnt;
    logic [31:0] hold;
    wcnt = 0;
    hold = 32'd0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt > 0 && mem_addr != hold) unstable++;
        hold = mem_addr;
        if (wcnt >= mem_lat) begin
          mem_ack = 1'b1;
          mem_rdata = 32'h11 * ({30'd0, mem_addr[3:2]} + 32'd1);
          if (ack_n < 64) ack_addr[ack_n] = mem_addr;
          ack_n++;
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise a miss and hold it until accepted; acc is the accepting cycle.
  task automatic do_miss(input logic [31:0] a, output int acc);
    bit ok;
    ok = 1'b0;
    acc = 0;
    miss_addr = a;
    miss_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (miss_ready) begin
        acc = cyc;
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    miss_req = 1'b0;
    check("miss_accept", {127'd0, ok}, 128'd1);
  endtask

  task automatic wait_done(input int base);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
    check("fill_done_seen", {127'd0, ok}, 128'd1);
  endtask

  initial begin
    int acc;
    int acc2;
    int ab;
    int ib;
    int db;
    int ub;
    bit found;

    rst = 1'b1;
    miss_req = 1'b0;
    miss_addr = 32'd0;
    repeat (3) step();
    check("rst_miss_ready", {127'd0, miss_ready}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd1);
    check("rst_init_entry", {127'd0, cc_initEntry}, 128'd0);
    check("rst_mem_req", {127'd0, mem_req}, 128'd0);
    check("rst_insert", {127'd0, cc_insert}, 128'd0);
    check("rst_fill_done", {127'd0, fill_done}, 128'd0);
    check("rst_cc_addr", {96'd0, cc_addr}, 128'd0);
    check("rst_line", cc_cacheLine, 128'd0);

    // Test 1: init sweep
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      step();
      check("init_entry", {127'd0, cc_initEntry}, 128'd1);
      check("init_addr", {96'd0, cc_addr}, 128'(k * 16));
    end
    step();
    check("init_ready", {127'd0, miss_ready}, 128'd1);
    check("init_entry_end", {127'd0, cc_initEntry}, 128'd0);
    check("idle_busy", {127'd0, busy}, 128'd0);

    // Test 2: zero-wait fill
    mem_lat = 0;
    ab = ack_n; ib = ins_cnt; db = done_cnt;
    do_miss(32'h0000_1238, acc);
    wait_done(db);
    check("t2_ins_lat", 128'(ins_cyc - acc), 128'd5);
    check("t2_done_lat", 128'(done_cyc - acc), 128'd6);
    check("t2_ins_cnt", 128'(ins_cnt - ib), 128'd1);
    check("t2_ins_addr", {96'd0, ins_addr}, 128'h1230);
    check("t2_line", ins_line, LINE_EXP);
    check("t2_beats", 128'(ack_n - ab), 128'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_mem_addr", {96'd0, ack_addr[ab+i]}, 128'(32'h1230 + 4 * i));
    end
    check("t2_ready_after", {127'd0, miss_ready}, 128'd1);
    check("t2_mem_req_off", {127'd0, mem_req}, 128'd0);

    // Test 3: three wait cycles per beat
    mem_lat = 3;
    ab = ack_n; db = done_cnt; ub = unstable;
    do_miss(32'h0000_1238, acc);
    wait_done(db);
    check("t3_ins_lat", 128'(ins_cyc - acc), 128'd17);
    check("t3_done_lat", 128'(done_cyc - acc), 128'd18);
    check("t3_addr_stable", 128'(unstable - ub), 128'd0);
    check("t3_line", ins_line, LINE_EXP);
    check("t3_beats", 128'(ack_n - ab), 128'd4);
    check("t3_last_addr", {96'd0, ack_addr[ab+3]}, 128'h123C);

    // Test 4: second miss raised mid-fill
    mem_lat = 0;
    do_miss(32'h0000_1238, acc);
    step();
    miss_addr = 32'h0000_2000;
    miss_req = 1'b1;
    check("t4_ready_busy", {127'd0, miss_ready}, 128'd0);
    check("t4_busy", {127'd0, busy}, 128'd1);
    found = 1'b0;
    acc2 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (miss_ready) begin
        acc2 = cyc;
        found = 1'b1;
        break;
      end
    end
    check("t4_accept", {127'd0, found}, 128'd1);
    check("t4_accept_cyc", 128'(acc2 - acc), 128'd7);
    check("t4_after_done", 128'(acc2 - done_cyc), 128'd1);
    ab = ack_n; db = done_cnt;
    step();
    miss_req = 1'b0;
    wait_done(db);
    check("t4_first_addr", {96'd0, ack_addr[ab]}, 128'h2000);
    check("t4_ins_addr", {96'd0, ins_addr}, 128'h2000);
    check("t4_ins_lat", 128'(ins_cyc - acc2), 128'd5);

    // Test 5: reset after the third beat aborts the fill
    ib = ins_cnt; db = done_cnt;
    do_miss(32'h0000_1238, acc);
    repeat (3) step();
    check("t5_mem_req_pre", {127'd0, mem_req}, 128'd1);
    rst = 1'b1;
    step();
    check("t5_mem_req_off", {127'd0, mem_req}, 128'd0);
    check("t5_no_insert", {127'd0, cc_insert}, 128'd0);
    check("t5_ready", {127'd0, miss_ready}, 128'd0);
    check("t5_busy", {127'd0, busy}, 128'd1);
    check("t5_line_clr", cc_cacheLine, 128'd0);
    rst = 1'b0;
    step();
    check("t5_init0_entry", {127'd0, cc_initEntry}, 128'd1);
    check("t5_init0_addr", {96'd0, cc_addr}, 128'h0);
    step();
    check("t5_init1_addr", {96'd0, cc_addr}, 128'h10);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (miss_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reinit_done", {127'd0, found}, 128'd1);
    check("t5_ins_none", 128'(ins_cnt - ib), 128'd0);
    check("t5_done_none", 128'(done_cnt - db), 128'd0);

`ifdef CODECACHE_FILL_CRITICAL_WORD_EN
    // Test 6: critical word first
    begin
      int cb;
      ab = ack_n; db = done_cnt; cb = crit_cnt;
      do_miss(32'h0000_1238, acc);
      wait_done(db);
      check("t6_order0", {96'd0, ack_addr[ab]},   128'h1238);
      check("t6_order1", {96'd0, ack_addr[ab+1]}, 128'h123C);
      check("t6_order2", {96'd0, ack_addr[ab+2]}, 128'h1230);
      check("t6_order3", {96'd0, ack_addr[ab+3]}, 128'h1234);
      check("t6_crit_cnt", 128'(crit_cnt - cb), 128'd1);
      check("t6_crit_data", {96'd0, crit_word}, 128'h33);
      check("t6_line", ins_line, LINE_EXP);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
